conv_row_sequencer: RTL and testbench
=====================================

# conv_row_sequencer

Frame-level controller that sequences the convolution datapath one output row at a time. For each output row it:

- drives the row loader's `load_en`/`row_count` handshake until a FILTER_SIZE-row window is buffered;
- pulses the convolution engine and waits for its completion;
- advances to the next window.

It sits between the top-level control (start/abort/status) and the row loader plus convolution engine, and is the only block that drives `row_count`.

## Interface
- IMAGE_WIDTH, 128, pixels per row (informational; passed through to status only)
- IMAGE_HEIGHT, 128, rows per frame
- FILTER_SIZE, 3, kernel height; output rows per frame = IMAGE_HEIGHT-FILTER_SIZE+1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to process a frame; honoured only in IDLE
- abort  in  1  level; forces return to IDLE from any state
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last output row completes
- load_en  out  1  level request to row loader
- row_count  out  16  top row of current window
- loaded  in  1  row loader window-ready flag (level, held while load_en high)
- conv_start  out  1  one-cycle pulse to convolution engine
- conv_done  in  1  one-cycle pulse from convolution engine
- rows_done  out  16  completed output rows in current frame

## Operation
- States: IDLE, LOAD, RELEASE, CONV, CONV_WAIT, NEXT.
- IDLE:
  - On start: row_count←0, rows_done←0, load_en←1, go to LOAD.
  - start in any other state is ignored (not queued).
- LOAD:
  - Hold load_en=1 and row_count stable.
  - On loaded=1: load_en←0, go to RELEASE.
- RELEASE:
  - Wait for loaded=0, which confirms the loader has returned to its idle state.
  - Then go to CONV.
  - load_en must not be re-asserted before loaded is seen low.
- CONV:
  - conv_start←1 for exactly one cycle, go to CONV_WAIT.
- CONV_WAIT:
  - On conv_done: rows_done←rows_done+1, go to NEXT.
  - conv_done in any other state is ignored.
- NEXT:
  - If row_count == IMAGE_HEIGHT-FILTER_SIZE: frame_done←1 (one cycle), go to IDLE.
  - Else: row_count←row_count+1, load_en←1, go to LOAD.
- abort (highest priority after reset), in any state:
  - next state IDLE; load_en←0 and conv_start←0 the same edge.
  - frame_done not pulsed; row_count and rows_done hold their values for debug.
- row_count never exceeds IMAGE_HEIGHT-FILTER_SIZE, so the loader's boundary path is never exercised.
- rows_done width is 16 bits; no wrap is possible for IMAGE_HEIGHT ≤ 65535.

## Timing
- Reset values: state IDLE, busy 0, frame_done 0, load_en 0, row_count 0, conv_start 0, rows_done 0.
- All outputs are registered; busy is decoded from the registered state.
- start→load_en: 1 cycle (load_en high on the edge after start is sampled).
- loaded sampled high → load_en low on the next edge.
- loaded low → conv_start pulses 1 cycle after RELEASE exit, i.e. 2 edges after loaded drops.
- conv_done → next load_en: 2 edges (CONV_WAIT→NEXT→LOAD).
- Last row: frame_done pulses on the edge leaving NEXT; busy falls the same edge.
- start and abort asserted together in IDLE: abort wins and the block stays IDLE.
- conv_done and abort in the same cycle: abort wins and rows_done does not increment.
- Minimum per-row overhead excluding loader and engine latency: 5 cycles.

## Structure
- Shared package `conv_pkg`:
  - state enum (IDLE..NEXT);
  - ROW_CNT_W = 16;
  - helper constant for out_rows = IMAGE_HEIGHT-FILTER_SIZE+1.
- Single module with no sub-modules. The row loader and convolution engine are instantiated beside it at top level, not inside it.

## Test plan
- Bench parameters are the same for every scenario: IMAGE_HEIGHT=5, FILTER_SIZE=3.
- Full frame: start, loader model asserts loaded 4 cycles after load_en, engine pulses conv_done 6 cycles after conv_start → row_count sequence 0,1,2; 3 conv_start pulses; rows_done=3; single frame_done; busy low afterwards.
- Handshake: loader holds loaded high 3 extra cycles after load_en drops → no conv_start until loaded low; load_en stays 0 throughout RELEASE.
- Abort in CONV_WAIT for row 1 → IDLE next edge; load_en=0; no frame_done; rows_done=1; a later start restarts at row_count=0.
- start pulsed while busy, and spurious conv_done in LOAD → both ignored; row sequence and counts identical to the full-frame case.
- Reset (rst=0) mid-LOAD → every output at its reset value on the next edge; start one cycle after release → load_en high after 1 cycle.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution row sequencer: state encoding,
// counter width and the output-row helper.
package conv_pkg;

  // Sequencer states, one output row per LOAD..NEXT loop
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RELEASE,
    CONV,
    CONV_WAIT,
    NEXT
  } state_e;

  // Width of row_count and rows_done
  localparam int ROW_CNT_W = 16;

  // Number of output rows a frame of the given height produces
  function automatic int out_rows(input int image_height, input int filter_size);
    return image_height - filter_size + 1;
  endfunction

endpackage

// File: rtl/conv_row_sequencer.sv
// Frame-level controller: walks a FILTER_SIZE-row window down the image,
// handshaking with the row loader and kicking the convolution engine once
// per output row. Sole driver of row_count.
module conv_row_sequencer
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int FILTER_SIZE  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 load_en,
  output logic [ROW_CNT_W-1:0] row_count,
  input  logic                 loaded,
  output logic                 conv_start,
  input  logic                 conv_done,
  output logic [ROW_CNT_W-1:0] rows_done
);

  // Top row of the final window; the window never moves past it, so the
  // loader never has to handle a partial window at the bottom edge.
  localparam logic [ROW_CNT_W-1:0] LAST_ROW =
    ROW_CNT_W'(out_rows(IMAGE_HEIGHT, FILTER_SIZE) - 1);

  // Geometry the sequencer cannot handle. IMAGE_WIDTH only matters to the
  // status path outside this block, so it is merely range-checked here.
  if (IMAGE_WIDTH < 1 || FILTER_SIZE < 1 || FILTER_SIZE > IMAGE_HEIGHT ||
      IMAGE_HEIGHT > 65535) begin : g_bad_geometry
    // Intentionally empty: an elaborated g_bad_geometry scope in the
    // hierarchy flags an unsupported parameter set.
  end

  state_e               state_q;
  logic                 frame_done_q;
  logic                 load_en_q;
  logic                 conv_start_q;
  logic [ROW_CNT_W-1:0] row_count_q;
  logic [ROW_CNT_W-1:0] rows_done_q;

  // Row-sequencing FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
      load_en_q    <= 1'b0;
      conv_start_q <= 1'b0;
      row_count_q  <= '0;
      rows_done_q  <= '0;
    end else if (abort) begin
      // Counters are left alone so the abort point stays visible
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
      load_en_q    <= 1'b0;
      conv_start_q <= 1'b0;
    end else begin
      // Pulse outputs default low each cycle
      frame_done_q <= 1'b0;
      conv_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            row_count_q <= '0;
            rows_done_q <= '0;
            load_en_q   <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (loaded) begin
            load_en_q <= 1'b0;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          // Loader must be seen back in idle before the next request can
          // ever be raised, otherwise a stale 'loaded' would be mistaken
          // for the next window.
          if (!loaded) begin
            state_q <= CONV;
          end
        end
        CONV: begin
          conv_start_q <= 1'b1;
          state_q      <= CONV_WAIT;
        end
        CONV_WAIT: begin
          if (conv_done) begin
            rows_done_q <= rows_done_q + ROW_CNT_W'(1);
            state_q     <= NEXT;
          end
        end
        NEXT: begin
          if (row_count_q == LAST_ROW) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            row_count_q <= row_count_q + ROW_CNT_W'(1);
            load_en_q   <= 1'b1;
            state_q     <= LOAD;
          end
        end
        default: begin
          load_en_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign load_en    = load_en_q;
  assign conv_start = conv_start_q;
  assign row_count  = row_count_q;
  assign rows_done  = rows_done_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Self-checking bench for conv_row_sequencer with a 5-row image and 3-row
// kernel (three output rows). Loader and engine are behavioural models;
// expected window rows are queued when a frame is started and popped on
// every conv_start.
module tb_conv_row_sequencer;

  localparam int IMAGE_WIDTH  = 8;
  localparam int IMAGE_HEIGHT = 5;
  localparam int FILTER_SIZE  = 3;
  localparam int N_ROWS       = IMAGE_HEIGHT - FILTER_SIZE + 1;
  localparam int LOAD_LAT     = 4;
  localparam int CONV_LAT     = 6;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        frame_done;
  logic        load_en;
  logic [15:0] row_count;
  logic        loaded;
  logic        conv_start;
  logic        conv_done;
  logic [15:0] rows_done;

  // Model state
  logic        eng_done;
  logic        spur_done;
  int          ld_cnt;
  int          hold_cnt;
  int          extra_hold;
  int          eng_cnt;
  int          drop_cnt;
  logic        rel;

  // Scoreboard and counters
  int          exp_rows[$];
  int          conv_cnt;
  int          fd_cnt;
  int          n_checks;
  int          n_fail;

  assign conv_done = eng_done | spur_done;

  conv_row_sequencer #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT),
    .FILTER_SIZE (FILTER_SIZE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .frame_done(frame_done),
    .load_en   (load_en),
    .row_count (row_count),
    .loaded    (loaded),
    .conv_start(conv_start),
    .conv_done (conv_done),
    .rows_done (rows_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Monitor first (sees values settled since the last rising edge), then
  // advance the loader and engine models for the next cycle.
  always @(negedge clk) begin
    if (conv_start) begin
      conv_cnt++;
      if (exp_rows.size() == 0) begin
        check_val("extra_conv_start", 32'd1, 32'd0);
      end else begin
        check_val("row_count", 32'(row_count), 32'(exp_rows.pop_front()));
      end
    end
    if (frame_done) begin
      fd_cnt++;
      check_val("busy_at_frame_done", 32'(busy), 32'd0);
    end
    if (rel) begin
      check_val("load_en_in_release", 32'(load_en), 32'd0);
      check_val("conv_start_while_loaded", 32'(conv_start), 32'd0);
    end
    if (drop_cnt > 0) begin
      drop_cnt--;
      if (drop_cnt == 0) check_val("loaded_low_to_conv_start", 32'(conv_start), 32'd1);
    end

    // Row loader model
    if (load_en) begin
      hold_cnt = 0;
      if (!loaded) begin
        ld_cnt++;
        if (ld_cnt >= LOAD_LAT) begin
          loaded = 1'b1;
          ld_cnt = 0;
        end
      end
    end else begin
      ld_cnt = 0;
      if (loaded) begin
        if (hold_cnt >= extra_hold) begin
          loaded   = 1'b0;
          drop_cnt = 2;
        end else begin
          hold_cnt++;
        end
      end
    end
    rel = loaded && !load_en;

    // Convolution engine model
    eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
    if (conv_start) eng_cnt = CONV_LAT;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check_val("start_to_load_en", 32'(load_en), 32'd1);
    check_val("start_row_count", 32'(row_count), 32'd0);
    start = 1'b0;
  endtask

  task automatic push_frame();
    for (int r = 0; r < N_ROWS; r++) exp_rows.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic clear_counts();
    conv_cnt = 0;
    fd_cnt   = 0;
  endtask

  task automatic check_frame_end(input string name);
    @(negedge clk);
    $display("-- %s end", name);
    check_val("conv_start_count", 32'(conv_cnt), N_ROWS);
    check_val("frame_done_count", 32'(fd_cnt), 32'd1);
    check_val("rows_done", 32'(rows_done), N_ROWS);
    check_val("final_row_count", 32'(row_count), N_ROWS - 1);
    check_val("scoreboard_empty", 32'(exp_rows.size()), 32'd0);
    check_val("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    $display("-- %s", name);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_load_en", 32'(load_en), 32'd0);
    check_val("rst_row_count", 32'(row_count), 32'd0);
    check_val("rst_conv_start", 32'(conv_start), 32'd0);
    check_val("rst_rows_done", 32'(rows_done), 32'd0);
  endtask

  initial begin
    int n;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    loaded     = 1'b0;
    eng_done   = 1'b0;
    spur_done  = 1'b0;
    ld_cnt     = 0;
    hold_cnt   = 0;
    extra_hold = 0;
    eng_cnt    = 0;
    drop_cnt   = 0;
    rel        = 1'b0;
    conv_cnt   = 0;
    fd_cnt     = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset state");
    @(negedge clk);
    rst = 1'b1;

    // Full frame
    clear_counts();
    push_frame();
    pulse_start();
    wait_idle(500);
    check_frame_end("full frame");

    // Loader holds loaded three extra cycles
    extra_hold = 3;
    clear_counts();
    push_frame();
    pulse_start();
    wait_idle(500);
    check_frame_end("handshake");
    extra_hold = 0;

    // Abort while the engine works on row 1
    clear_counts();
    push_frame();
    pulse_start();
    n = 0;
    while (!(conv_start && row_count == 16'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("reach_row1_conv", 32'(n < 500), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    $display("-- abort");
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_load_en", 32'(load_en), 32'd0);
    check_val("abort_rows_done", 32'(rows_done), 32'd1);
    check_val("abort_row_count", 32'(row_count), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    exp_rows.delete();
    repeat (12) @(negedge clk);
    check_val("abort_no_frame_done", 32'(fd_cnt), 32'd0);
    check_val("abort_rows_done_hold", 32'(rows_done), 32'd1);
    check_val("abort_still_idle", 32'(busy), 32'd0);
    clear_counts();
    push_frame();
    pulse_start();
    wait_idle(500);
    check_frame_end("restart after abort");

    // start while busy and a spurious conv_done during LOAD
    clear_counts();
    push_frame();
    pulse_start();
    n = 0;
    while (!(load_en && !loaded && row_count == 16'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("reach_row1_load", 32'(n < 500), 32'd1);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(500);
    check_frame_end("ignored start and conv_done");

    // Reset in the middle of LOAD
    clear_counts();
    push_frame();
    pulse_start();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset mid-LOAD");
    @(negedge clk);
    rst = 1'b1;
    exp_rows.delete();
    clear_counts();
    push_frame();
    pulse_start();
    wait_idle(500);
    check_frame_end("frame after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
